// File: rtl/ram256x64_bist.sv
`default_nettype none
// ============================================================================
// Module   : ram256x64_bist
// Purpose  : Writes an LFSR pattern to a 256x64 RAM, reads it back and reports
//            pass, mismatch count and first failing address.
// Revision : 1.0  initial release
// ============================================================================
module ram256x64_bist #(
    parameter int               DEPTH        = 256,
    parameter int               WIDTH        = 64,
    parameter int               READ_LATENCY = 1,
    parameter logic [WIDTH-1:0] SEED         = 64'h0123_4567_89AB_CDEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    output logic [63:0]      mem_address,
    output logic [WIDTH-1:0] mem_in,
    output logic             mem_write,
    input  logic [WIDTH-1:0] mem_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [8:0]       err_count,
    output logic [7:0]       first_err_addr
);

    localparam logic [WIDTH-1:0] c_TAPS = 64'hD800_0000_0000_0000;
    localparam logic [7:0]       c_LAST = 8'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  r_state;
    logic [7:0]              r_idx;
    logic [WIDTH-1:0]        r_wr_lfsr;
    logic [WIDTH-1:0]        r_exp_lfsr;
    logic [WIDTH-1:0]        r_wdata;
    logic [7:0]              r_addr;
    logic                    r_we;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_pass;
    logic [8:0]              r_errs;
    logic [7:0]              r_first;
    logic [READ_LATENCY-1:0] r_vld;
    logic [7:0]              r_apipe [READ_LATENCY];
    logic                    w_mismatch;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
        return (v >> 1) ^ (v[0] ? c_TAPS : '0);
    endfunction

    assign w_mismatch = r_vld[READ_LATENCY-1] && (mem_out != r_exp_lfsr);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_idx      <= 8'd0;
            r_wr_lfsr  <= SEED;
            r_exp_lfsr <= SEED;
            r_wdata    <= '0;
            r_addr     <= 8'd0;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_errs     <= 9'd0;
            r_first    <= 8'd0;
            r_vld      <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_apipe[k] <= 8'd0;
            end
        end else begin
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            r_wdata <= '0;

            // Read-back compare runs off the delayed valid, independent of state.
            if (r_vld[READ_LATENCY-1]) begin
                r_exp_lfsr <= lfsr_step(r_exp_lfsr);
                if (w_mismatch) begin
                    r_errs <= r_errs + 9'd1;
                    if (r_errs == 9'd0) begin
                        r_first <= r_apipe[READ_LATENCY-1];
                    end
                end
            end

            r_vld[0]   <= 1'b0;
            r_apipe[0] <= r_idx;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_vld[k]   <= r_vld[k-1];
                r_apipe[k] <= r_apipe[k-1];
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_errs     <= 9'd0;
                        r_first    <= 8'd0;
                        r_pass     <= 1'b0;
                        r_wr_lfsr  <= SEED;
                        r_exp_lfsr <= SEED;
                        r_idx      <= 8'd0;
                        r_busy     <= 1'b1;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_we      <= 1'b1;
                    r_addr    <= r_idx;
                    r_wdata   <= r_wr_lfsr;
                    r_wr_lfsr <= lfsr_step(r_wr_lfsr);
                    r_idx     <= r_idx + 8'd1;
                    if (r_idx == c_LAST) begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_addr   <= r_idx;
                    r_vld[0] <= 1'b1;
                    r_idx    <= r_idx + 8'd1;
                    if (r_idx == c_LAST) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_vld == '0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (r_errs == 9'd0);
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // A restart here issues the first write straight away so
                    // back-to-back tests leave no gap after done.
                    if (start) begin
                        r_errs     <= 9'd0;
                        r_first    <= 8'd0;
                        r_pass     <= 1'b0;
                        r_exp_lfsr <= SEED;
                        r_we       <= 1'b1;
                        r_addr     <= 8'd0;
                        r_wdata    <= SEED;
                        r_wr_lfsr  <= lfsr_step(SEED);
                        r_idx      <= 8'd1;
                        r_busy     <= 1'b1;
                        r_state    <= S_WRITE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_address    = {56'd0, r_addr};
    assign mem_in         = r_wdata;
    assign mem_write      = r_we;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_errs;
    assign first_err_addr = r_first;

endmodule
`default_nettype wire

// File: tb/tb_ram256x64_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram256x64_bist
// Purpose  : Self-checking bench for ram256x64_bist with RAM models and faults.
// Revision : 1.0  initial release
// ============================================================================
module tb_ram256x64_bist;

    localparam logic [63:0] c_SEED = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] c_TAPS = 64'hD800_0000_0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start1, start2;
    logic [63:0] addr1, in1, out1, addr2, in2, out2;
    logic        we1, busy1, done1, pass1, we2, busy2, done2, pass2;
    logic [8:0]  err1, err2;
    logic [7:0]  first1, first2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference pattern and RAM models
    logic [63:0] pat  [256];
    logic [63:0] mem1 [256];
    logic [63:0] mem2 [256];
    logic [63:0] flip [256];
    logic [63:0] q1, q2;
    logic        stuck = 1'b0;
    logic        regmode = 1'b0;

    always @(posedge clk) begin
        if (we1) mem1[addr1[7:0]] <= in1;
        q1 <= mem1[addr1[7:0]];
        if (we2) mem2[addr2[7:0]] <= in2;
        q2 <= mem2[addr2[7:0]];
    end

    assign out1 = regmode ? q1 : (stuck ? 64'h0 : (mem1[addr1[7:0]] ^ flip[addr1[7:0]]));
    assign out2 = q2;

    // Write-order scoreboard and upper-address monitor
    logic [7:0] wr_idx = 8'd0;
    int         wr_bad = 0;
    int         hi_bad = 0;
    always @(negedge clk) begin
        if (addr1[63:8] != 56'd0 || addr2[63:8] != 56'd0) hi_bad <= hi_bad + 1;
        if (we1) begin
            if (addr1[7:0] != wr_idx || in1 !== pat[wr_idx]) wr_bad <= wr_bad + 1;
            wr_idx <= wr_idx + 8'd1;
        end else if (!busy1) begin
            wr_idx <= 8'd0;
        end
    end

    ram256x64_bist #(.READ_LATENCY(1)) dut (
        .clock(clk), .reset_n(reset_n), .start(start1),
        .mem_address(addr1), .mem_in(in1), .mem_write(we1), .mem_out(out1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_addr(first1)
    );

    ram256x64_bist #(.READ_LATENCY(2)) dut2 (
        .clock(clk), .reset_n(reset_n), .start(start2),
        .mem_address(addr2), .mem_in(in2), .mem_write(we2), .mem_out(out2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_err_addr(first2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected outcome of one test given the current fault setup.
    function automatic void model(output logic [8:0] e, output logic [7:0] f);
        logic [63:0] got;
        e = 9'd0;
        f = 8'd0;
        for (int a = 0; a < 256; a++) begin
            got = stuck ? 64'h0 : (pat[a] ^ flip[a]);
            if (got != pat[a]) begin
                if (e == 9'd0) f = 8'(a);
                e = e + 9'd1;
            end
        end
    endfunction

    function automatic int image_errs();
        int n = 0;
        for (int a = 0; a < 256; a++) if (mem1[a] !== pat[a]) n++;
        return n;
    endfunction

    task automatic clear_faults();
        for (int a = 0; a < 256; a++) flip[a] = 64'h0;
        stuck = 1'b0;
    endtask

    task automatic run1(input string tag, input logic [8:0] exp_e, input logic [7:0] exp_f,
                        input bit poke, input bit chk_wr);
        int c0;
        bit found;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        c0 = cyc;
        start1 = 1'b0;
        check({tag, "_pass_clr"}, pass1, 0);
        check({tag, "_busy"}, busy1, 1);
        found = 1'b0;
        for (int k = 0; k < 700 && !found; k++) begin
            @(negedge clk);
            if (chk_wr && k == 0) begin
                check("first_wr_en", we1, 1);
                check("first_wr_addr", addr1, 0);
                check("first_wr_data", in1, c_SEED);
            end
            if (done1) found = 1'b1;
            else start1 = poke && busy1 && k < 480 && ($urandom_range(0, 15) == 0);
        end
        start1 = 1'b0;
        check({tag, "_done_seen"}, found, 1);
        check({tag, "_latency"}, cyc - c0, 514);
        check({tag, "_pass"}, pass1, exp_e == 9'd0);
        check({tag, "_errs"}, err1, exp_e);
        check({tag, "_first"}, first1, exp_f);
        check({tag, "_image"}, image_errs(), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done1, 0);
    endtask

    initial begin
        int          c0, t1, t2, a, ndone;
        bit          found;
        logic [63:0] m;
        logic [8:0]  me;
        logic [7:0]  mf;

        pat[0] = c_SEED;
        for (int i = 1; i < 256; i++)
            pat[i] = (pat[i-1] >> 1) ^ (pat[i-1][0] ? c_TAPS : 64'h0);
        clear_faults();
        start1  = 1'b0;
        start2  = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr", addr1, 0);
        check("rst_in", in1, 0);
        check("rst_we", we1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_pass", pass1, 0);
        check("rst_errs", err1, 0);
        check("rst_first", first1, 0);
        reset_n = 1'b1;

        run1("ideal", 9'd0, 8'h00, 1'b0, 1'b1);

        flip[8'h3C] = 64'h20;
        run1("bit5", 9'd1, 8'h3C, 1'b0, 1'b0);
        clear_faults();

        stuck = 1'b1;
        run1("stuck0", 9'd256, 8'h00, 1'b0, 1'b0);
        clear_faults();

        for (int r = 0; r < 3; r++) begin
            clear_faults();
            repeat ($urandom_range(1, 6)) begin
                a = $urandom_range(0, 255);
                m = {$urandom, $urandom};
                if (m == 64'h0) m = 64'h1;
                flip[a] = m;
            end
            model(me, mf);
            run1("rand", me, mf, 1'b1, 1'b0);
        end
        clear_faults();

        // Reset while address 100 is being written
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (we1 && addr1[7:0] == 8'd100) found = 1'b1;
        end
        check("mid_found", found, 1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mid_we", we1, 0);
        check("mid_busy", busy1, 0);
        check("mid_done", done1, 0);
        ndone = 0;
        repeat (600) begin
            @(negedge clk);
            if (done1) ndone++;
        end
        check("mid_no_done", ndone, 0);
        run1("after_rst", 9'd0, 8'h00, 1'b0, 1'b0);

        // start held high: back-to-back runs
        start1 = 1'b1;
        @(negedge clk);
        c0 = cyc;
        found = 1'b0;
        for (int k = 0; k < 700 && !found; k++) begin
            @(negedge clk);
            if (done1) found = 1'b1;
        end
        t1 = cyc;
        check("b2b_done1", found, 1);
        check("b2b_lat1", t1 - c0, 514);
        check("b2b_pass1", pass1, 1);
        @(negedge clk);
        check("b2b_wr_en", we1, 1);
        check("b2b_wr_addr", addr1, 0);
        check("b2b_wr_data", in1, c_SEED);
        found = 1'b0;
        for (int k = 0; k < 700 && !found; k++) begin
            @(negedge clk);
            if (done1) found = 1'b1;
        end
        t2 = cyc;
        start1 = 1'b0;
        check("b2b_done2", found, 1);
        check("b2b_period", t2 - t1, 514);
        check("b2b_pass2", pass1, 1);
        @(negedge clk);
        check("b2b_idle_done", done1, 0);
        check("b2b_idle_busy", busy1, 0);

        // Registered-read RAM against a latency-1 initiator
        regmode = 1'b1;
        run1("regrd_lat1", 9'd256, 8'h00, 1'b0, 1'b0);
        regmode = 1'b0;

        // Latency-2 initiator against registered-read RAM
        repeat (2) @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        c0 = cyc;
        start2 = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 700 && !found; k++) begin
            @(negedge clk);
            if (done2) found = 1'b1;
        end
        check("rl2_done", found, 1);
        check("rl2_latency", cyc - c0, 515);
        check("rl2_pass", pass2, 1);
        check("rl2_errs", err2, 0);
        check("rl2_first", first2, 0);

        check("wr_sequence", wr_bad, 0);
        check("addr_upper", hi_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
